// File: rtl/hpm_counters.sv
// hpm_counters: cycle/time/instret base counters plus N_HPM event-driven
// hardware performance counters, sharing the execute-stage CSR bus.
//
// Ports:
//   clk      - clock
//   reset    - asynchronous, active-low reset
//   cmd      - CSR command: 0 idle, 1 read, 2 write, 3 set, 4 clear
//   addr     - CSR address
//   wdata    - write/set/clear operand
//   retire   - one instruction retired this cycle (instret increment)
//   events   - per-cycle event pulses; bit k is event number k+1
//   rdata    - combinational read data (0 on illegal or unmapped access)
//   illegal  - combinational; access rejected, no state change
//   ovf_irq  - OR of the sticky overflow flags
//
// Map: counter i low half at 0xB00+i (rw) / 0xC00+i (ro), high half at
// 0xB80+i (rw) / 0xC80+i (ro); mcountinhibit 0x320; mhpmevent 0x323+j;
// mhpmovf 0x7C0. Counter 1 (time) is read-only everywhere.
module hpm_counters #(
  parameter int XLEN         = 32,
  parameter int CNT_LEN      = 64,
  parameter int N_HPM        = 4,
  parameter int N_EVENTS     = 8,
  parameter int CSR_CMD_LEN  = 3,
  parameter int CSR_ADDR_LEN = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CSR_CMD_LEN-1:0]  cmd,
  input  logic [CSR_ADDR_LEN-1:0] addr,
  input  logic [XLEN-1:0]         wdata,
  input  logic                    retire,
  input  logic [N_EVENTS-1:0]     events,
  output logic [XLEN-1:0]         rdata,
  output logic                    illegal,
  output logic                    ovf_irq
);

  localparam logic [CSR_CMD_LEN-1:0] CSR_IDLE  = CSR_CMD_LEN'(0);
  localparam logic [CSR_CMD_LEN-1:0] CSR_WRITE = CSR_CMD_LEN'(2);
  localparam logic [CSR_CMD_LEN-1:0] CSR_SET   = CSR_CMD_LEN'(3);
  localparam logic [CSR_CMD_LEN-1:0] CSR_CLEAR = CSR_CMD_LEN'(4);

  localparam int NC = 3 + N_HPM;
  localparam int HW = CNT_LEN - XLEN;
  localparam int EW = $clog2(N_EVENTS + 1);
  // Implemented bits of mcountinhibit / mhpmovf: everything except time.
  localparam logic [NC-1:0] IMPL = ~(NC'(2));

  logic [CNT_LEN-1:0] cnt [NC];
  logic [NC-1:0]      inhibit;
  logic [NC-1:0]      ovf;
  logic [EW-1:0]      evsel [N_HPM];

  logic [XLEN-1:0]  cur;
  logic [XLEN-1:0]  nv;
  logic             hit;
  logic             ro;
  logic             is_wr;
  logic             we;
  logic             sel_inh;
  logic             sel_ovf;
  logic [NC-1:0]    sel_lo;
  logic [NC-1:0]    sel_hi;
  logic [N_HPM-1:0] sel_ev;
  logic [N_HPM-1:0] ev_hit;
  logic [NC-1:0]    inc;
  logic [NC-1:0]    wrap;

  // Address decode, read mux and write-value formation.
  always_comb begin
    hit     = 1'b0;
    ro      = 1'b0;
    cur     = '0;
    sel_lo  = '0;
    sel_hi  = '0;
    sel_ev  = '0;
    sel_inh = 1'b0;
    sel_ovf = 1'b0;
    for (int unsigned i = 0; i < NC; i++) begin
      if (addr == CSR_ADDR_LEN'(32'hB00 + i)) begin
        hit = 1'b1;
        cur = cnt[i][XLEN-1:0];
        if (i == 1) ro = 1'b1;
        else        sel_lo[i] = 1'b1;
      end
      if (addr == CSR_ADDR_LEN'(32'hB80 + i)) begin
        hit = 1'b1;
        cur = XLEN'(cnt[i][CNT_LEN-1:XLEN]);
        if (i == 1) ro = 1'b1;
        else        sel_hi[i] = 1'b1;
      end
      if (addr == CSR_ADDR_LEN'(32'hC00 + i)) begin
        hit = 1'b1;
        ro  = 1'b1;
        cur = cnt[i][XLEN-1:0];
      end
      if (addr == CSR_ADDR_LEN'(32'hC80 + i)) begin
        hit = 1'b1;
        ro  = 1'b1;
        cur = XLEN'(cnt[i][CNT_LEN-1:XLEN]);
      end
    end
    for (int unsigned j = 0; j < N_HPM; j++) begin
      if (addr == CSR_ADDR_LEN'(32'h323 + j)) begin
        hit       = 1'b1;
        cur       = XLEN'(evsel[j]);
        sel_ev[j] = 1'b1;
      end
    end
    if (addr == CSR_ADDR_LEN'(32'h320)) begin
      hit     = 1'b1;
      cur     = XLEN'(inhibit);
      sel_inh = 1'b1;
    end
    if (addr == CSR_ADDR_LEN'(32'h7C0)) begin
      hit     = 1'b1;
      cur     = XLEN'(ovf);
      sel_ovf = 1'b1;
    end

    is_wr   = (cmd == CSR_WRITE) || (cmd == CSR_SET) || (cmd == CSR_CLEAR);
    illegal = (cmd != CSR_IDLE) && (!hit || (ro && is_wr));
    rdata   = illegal ? '0 : cur;
    we      = is_wr && !illegal;

    case (cmd)
      CSR_WRITE: nv = wdata;
      CSR_SET:   nv = cur | wdata;
      CSR_CLEAR: nv = cur & ~wdata;
      default:   nv = cur;
    endcase
  end

  // Increment enables and wrap detection; a same-cycle write to the
  // counter wins over both its increment and its overflow flag.
  always_comb begin
    ev_hit = '0;
    for (int unsigned j = 0; j < N_HPM; j++) begin
      for (int unsigned k = 0; k < N_EVENTS; k++) begin
        if (evsel[j] == EW'(k + 1) && events[k]) ev_hit[j] = 1'b1;
      end
    end
    inc    = '0;
    inc[0] = ~inhibit[0];
    inc[1] = 1'b1;
    inc[2] = ~inhibit[2] & retire;
    for (int unsigned j = 0; j < N_HPM; j++) begin
      inc[3+j] = ~inhibit[3+j] & ev_hit[j];
    end
    wrap = '0;
    for (int unsigned i = 0; i < NC; i++) begin
      wrap[i] = inc[i] && (&cnt[i]) && !(we && (sel_lo[i] || sel_hi[i]));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NC; i++) cnt[i] <= '0;
      for (int unsigned j = 0; j < N_HPM; j++) evsel[j] <= '0;
      inhibit <= '0;
      ovf     <= '0;
    end else begin
      for (int unsigned i = 0; i < NC; i++) begin
        if (we && sel_lo[i])      cnt[i][XLEN-1:0]       <= nv;
        else if (we && sel_hi[i]) cnt[i][CNT_LEN-1:XLEN] <= nv[HW-1:0];
        else if (inc[i])          cnt[i]                 <= cnt[i] + CNT_LEN'(1);
      end
      for (int unsigned j = 0; j < N_HPM; j++) begin
        if (we && sel_ev[j]) evsel[j] <= nv[EW-1:0];
      end
      if (we && sel_inh) inhibit <= nv[NC-1:0] & IMPL;
      // A wrap in the same cycle as a software write still sets its flag.
      ovf <= (((we && sel_ovf) ? nv[NC-1:0] : ovf) | wrap) & IMPL;
    end
  end

  assign ovf_irq = |ovf;

endmodule

// File: tb/tb_hpm_counters.sv
// Scoreboard bench for hpm_counters: each CSR op pushes its expected
// rdata/illegal/ovf_irq; a negedge monitor pops and compares whenever a
// non-idle command is on the bus. Expected values are hand-computed,
// counting posedges from reset release ("P0" = the edge just before it).
module tb_hpm_counters;

  localparam logic [2:0] C_IDLE  = 3'd0;
  localparam logic [2:0] C_READ  = 3'd1;
  localparam logic [2:0] C_WRITE = 3'd2;
  localparam logic [2:0] C_SET   = 3'd3;
  localparam logic [2:0] C_CLEAR = 3'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  cmd = C_IDLE;
  logic [11:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        retire = 1'b0;
  logic [7:0]  events = '0;
  logic [31:0] rdata;
  logic        illegal;
  logic        ovf_irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        ill;
    logic        irq;
    bit          chk_rd;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  hpm_counters #(
    .XLEN(32), .CNT_LEN(64), .N_HPM(4), .N_EVENTS(8),
    .CSR_CMD_LEN(3), .CSR_ADDR_LEN(12)
  ) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .addr(addr), .wdata(wdata),
    .retire(retire), .events(events), .rdata(rdata), .illegal(illegal),
    .ovf_irq(ovf_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached with %0d pending", q.size());
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (cmd != C_IDLE) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: op at addr %h with no expectation", addr);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.chk_rd) begin
          checks++;
          if (rdata !== mon_e.rd) begin
            errors++;
            $display("FAIL %s rdata: got %h expected %h", mon_e.name, rdata, mon_e.rd);
          end
        end
        checks++;
        if (illegal !== mon_e.ill) begin
          errors++;
          $display("FAIL %s illegal: got %b expected %b", mon_e.name, illegal, mon_e.ill);
        end
        checks++;
        if (ovf_irq !== mon_e.irq) begin
          errors++;
          $display("FAIL %s ovf_irq: got %b expected %b", mon_e.name, ovf_irq, mon_e.irq);
        end
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic op(input logic [2:0] c, input logic [11:0] a, input logic [31:0] wd,
                    input string nm, input logic [31:0] erd, input bit eill,
                    input bit eirq, input bit crd);
    exp_t e;
    e.name = nm; e.rd = erd; e.ill = eill; e.irq = eirq; e.chk_rd = crd;
    q.push_back(e);
    cmd = c; addr = a; wdata = wd;
    step(1);
    cmd = C_IDLE;
  endtask

  task automatic rd(input logic [11:0] a, input string nm, input logic [31:0] erd,
                    input bit eirq);
    op(C_READ, a, '0, nm, erd, 1'b0, eirq, 1'b1);
  endtask

  // Leaves the bench just after P0 with all state cleared.
  task automatic do_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  initial begin
    step(1);
    // Base counters
    do_reset();
    retire = 1'b1;
    step(3);
    retire = 1'b0;
    step(7);
    rd(12'hC00, "cycle_10", 32'd10, 0);
    rd(12'hC01, "time_11", 32'd11, 0);
    rd(12'hC02, "instret_3", 32'd3, 0);
    rd(12'hC80, "cycle_hi", 32'd0, 0);
    reset = 1'b0;
    rd(12'hC00, "rst_cycle", 32'd0, 0);
    rd(12'hC02, "rst_instret", 32'd0, 0);

    // Event selection
    do_reset();
    op(C_WRITE, 12'h323, 32'd2, "wr_ev2", 32'd0, 0, 0, 1);
    events = 8'h02;
    step(5);
    events = 8'h01;
    step(4);
    events = 8'h00;
    rd(12'hB03, "hpm3_5", 32'd5, 0);
    rd(12'hC03, "hpm3_ro_5", 32'd5, 0);
    rd(12'hB83, "hpm3_hi", 32'd0, 0);
    op(C_WRITE, 12'h323, 32'd9, "wr_ev9", 32'd2, 0, 0, 1);
    events = 8'hFF;
    step(3);
    events = 8'h00;
    rd(12'hB03, "hpm3_frozen", 32'd5, 0);
    rd(12'h323, "ev_rd9", 32'd9, 0);
    op(C_WRITE, 12'h323, 32'h12, "wr_ev_trunc", 32'd9, 0, 0, 1);
    rd(12'h323, "ev_trunc", 32'd2, 0);

    // Inhibit
    do_reset();
    op(C_WRITE, 12'h323, 32'd1, "wr_ev1", 32'd0, 0, 0, 1);
    events = 8'h01;
    op(C_WRITE, 12'h320, 32'h9, "wr_inh9", 32'd0, 0, 0, 1);
    step(20);
    rd(12'hC00, "inh_cycle", 32'd2, 0);
    rd(12'hC01, "inh_time", 32'd23, 0);
    rd(12'hC03, "inh_hpm3", 32'd1, 0);
    rd(12'h320, "inh_rd", 32'h9, 0);
    op(C_WRITE, 12'h320, 32'hFFFF_FFFF, "wr_inh_all", 32'h9, 0, 0, 1);
    rd(12'h320, "inh_mask", 32'h7D, 0);
    events = 8'h00;

    // Overflow
    do_reset();
    op(C_WRITE, 12'hB80, 32'hFFFF_FFFF, "wr_hi", 32'd0, 0, 0, 1);
    op(C_WRITE, 12'hB00, 32'hFFFF_FFFE, "wr_lo", 32'd0, 0, 0, 1);
    step(1);
    rd(12'h7C0, "ovf_pre", 32'd0, 0);
    rd(12'hB00, "wrap_lo", 32'd0, 1);
    rd(12'hB80, "wrap_hi", 32'd0, 1);
    rd(12'h7C0, "ovf_set", 32'd1, 1);
    op(C_CLEAR, 12'h7C0, 32'd1, "ovf_clr", 32'd1, 0, 1, 1);
    rd(12'h7C0, "ovf_cleared", 32'd0, 0);
    op(C_WRITE, 12'hB82, 32'hFFFF_FFFF, "wr_ir_hi", 32'd0, 0, 0, 1);
    op(C_WRITE, 12'hB02, 32'hFFFF_FFFF, "wr_ir_lo", 32'd0, 0, 0, 1);
    retire = 1'b1;
    op(C_WRITE, 12'h7C0, 32'd0, "ovf_wr_wrap", 32'd0, 0, 0, 1);
    retire = 1'b0;
    rd(12'h7C0, "ovf_set_wins", 32'd4, 1);
    op(C_WRITE, 12'h7C0, 32'hFFFF_FFFF, "ovf_wr_all", 32'd4, 0, 1, 1);
    rd(12'h7C0, "ovf_mask", 32'h7D, 1);
    op(C_WRITE, 12'h7C0, 32'd0, "ovf_wr0", 32'h7D, 0, 1, 1);
    rd(12'h7C0, "ovf_zero", 32'd0, 0);

    // Write/increment conflicts and set/clear
    do_reset();
    op(C_WRITE, 12'hB80, 32'd5, "cf_wr_hi", 32'd0, 0, 0, 1);
    op(C_WRITE, 12'hB00, 32'h100, "cf_wr_lo", 32'd0, 0, 0, 1);
    rd(12'hB00, "cf_lo", 32'h100, 0);
    rd(12'hB80, "cf_hi", 32'd5, 0);
    rd(12'hB00, "cf_lo_run", 32'h102, 0);
    op(C_WRITE, 12'hB02, 32'h0F, "wr_ir", 32'd0, 0, 0, 1);
    op(C_SET, 12'hB02, 32'hF0, "set_ir", 32'h0F, 0, 0, 1);
    rd(12'hC02, "set_res", 32'hFF, 0);
    op(C_CLEAR, 12'hB02, 32'h0F, "clr_ir", 32'hFF, 0, 0, 1);
    rd(12'hC02, "clr_res", 32'hF0, 0);

    // Illegal accesses
    do_reset();
    op(C_WRITE, 12'hC00, 32'h1234, "ill_wr_c00", 32'd0, 1, 0, 1);
    op(C_WRITE, 12'hB81, 32'h1234, "ill_wr_b81", 32'd0, 1, 0, 1);
    op(C_WRITE, 12'h7FF, 32'h1234, "ill_wr_7ff", 32'd0, 1, 0, 1);
    op(C_READ, 12'h7FF, 32'd0, "ill_rd_7ff", 32'd0, 1, 0, 1);
    op(C_SET, 12'hC02, 32'hFF, "ill_set_c02", 32'd0, 1, 0, 1);
    rd(12'hC00, "ill_nochg_lo", 32'd5, 0);
    rd(12'hC80, "ill_nochg_hi", 32'd0, 0);
    op(C_READ, 12'hB07, 32'd0, "ill_rd_b07", 32'd0, 1, 0, 1);
    op(C_READ, 12'h327, 32'd0, "ill_rd_327", 32'd0, 1, 0, 1);
    rd(12'hC01, "ill_time", 32'd9, 0);
    op(C_CLEAR, 12'hB01, 32'hFFFF_FFFF, "ill_clr_b01", 32'd0, 1, 0, 1);
    rd(12'hC02, "ill_instret", 32'd0, 0);

    step(2);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
